svd_seq_mxn: RTL
================

# svd_seq_mxn

Parametrised sequencer for the one-sided Jacobi / CORDIC SVD engine. It generalises the fixed 8x4 control unit to 2^ROW_AW x 2^COL_AW matrices, a configurable CORDIC latency and sweep count, and ready/valid load and unload handshakes. It drives the column-pair rotation schedule, the A/V store write enables, V clear, and CORDIC start, and sits between the host stream and the data path plus stores.

## Interface
- ROW_AW, 3, log2 of row count M
- COL_AW, 2, log2 of column count N (N >= 2)
- N_SWEEP, 6, maximum sweeps, 1..15
- CORDIC_LAT, 16, CORDIC latency in cycles, 1..255
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin decomposition; sampled only in IDLE
- in_valid  in  1  load beat valid (one column per beat)
- in_ready  out  1  sequencer accepts a load beat
- out_ready  in  1  consumer accepts an unload beat
- out_valid  out  1  unload beat valid
- rot_small  in  1  CORDIC reports off-diagonal below threshold; sampled in WB
- col_idx  out  COL_AW  column being loaded or unloaded
- col_p, col_q  out  COL_AW each  current rotation pair, p < q
- ce_rot  out  1  CORDIC start pulse
- we_a, we_v  out  1  A-store and V-store write enables
- clr_v  out  1  one-cycle V-to-identity clear
- busy  out  1  state != IDLE
- sweep_cnt  out  4  completed sweeps
- done  out  1  one-cycle completion pulse, registered

## Operation
- States: IDLE, LOAD, ROT, WAIT, WB, UNLOAD. Outputs are Moore decodes of registered state and counters. done is a register.
- IDLE: If start is high, go to LOAD, set col_idx=0 and sweep_cnt=0, and pulse clr_v in the same cycle as the start sample.
- LOAD: in_ready=1. Each in_valid&in_ready beat asserts we_a for column col_idx and increments col_idx. On the beat at col_idx=N-1, go to ROT with p=0, q=1.
- ROT: One cycle with ce_rot=1. Load the wait counter with CORDIC_LAT-1, then go to WAIT.
- WAIT: Decrement the counter each cycle. At 0, go to WB. WAIT lasts exactly CORDIC_LAT cycles.
- WB: One cycle with we_a=we_v=1 for the pair (p,q).
  - Pair advance is cyclic-by-rows: if q<N-1, q++. Otherwise p++ and q=p+1.
  - After pair (N-2,N-1) the sweep ends: sweep_cnt++.
  - If sweep_cnt reaches N_SWEEP, go to UNLOAD with col_idx=0. Otherwise restart at p=0, q=1 and go to ROT.
- UNLOAD: out_valid=1. Each out_valid&out_ready beat increments col_idx. After beat N-1, go to IDLE and pulse done.
- Boundaries:
  - start during busy is ignored.
  - in_valid outside LOAD and out_ready outside UNLOAD are ignored.
  - Stalled handshakes hold state indefinitely.
  - Asserting rst_n low at any point returns the block to IDLE and zeroes all outputs and counters. No partial done is produced.
  - col_idx, p, and q never exceed N-1.

## Timing
- Reset values are 0 for every output, including in_ready, out_valid, busy, done, and sweep_cnt.
- Cycles per pair = CORDIC_LAT+2. Cycles per sweep = N(N-1)/2 x (CORDIC_LAT+2).
- Full run, no stalls: start is sampled at edge 0, and done is high after edge 1 + N + N_SWEEP x sweep + N - 1 ... i.e. 2N + N_SWEEP x N(N-1)/2 x (CORDIC_LAT+2). Defaults give 8 + 648 = 656.
- ce_rot fires exactly CORDIC_LAT+1 cycles before the matching we_a/we_v.

## Configuration
- SVD_SEQ_EARLY_EXIT_EN, when defined:
  - An all_small flag is set at each sweep start.
  - The flag is ANDed with rot_small in every WB cycle.
  - If the flag is still set at sweep end, go to UNLOAD regardless of sweep_cnt.
- When undefined, rot_small is ignored and exactly N_SWEEP sweeps always run.

## Test plan
- Defaults, continuous valid/ready, rot_small=0 -> done exactly 656 cycles after start. sweep_cnt=6. 36 ce_rot pulses. 36 we_v pulses. clr_v pulses once.
- Pair order check with N=4 -> (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) each sweep, then back to (0,1).
- in_valid toggled every other cycle, and out_ready held low 10 cycles mid-unload -> FSM stalls, and each stall adds 1:1 to done latency. No dropped or duplicate col_idx.
- start re-pulsed in ROT/WAIT -> ignored. rst_n low during WAIT of sweep 3 -> all outputs 0 next cycle. A fresh start then runs the full 656 cycles.
- CORDIC_LAT=1, COL_AW=1 -> one pair/sweep, 3 cycles per pair, done after 4+6x3=22 cycles.
- With SVD_SEQ_EARLY_EXIT_EN, rot_small=1 during sweep 2 -> UNLOAD after sweep 2, sweep_cnt=2. Without the macro, same stimulus -> sweep_cnt=6.

Source files
------------

// File: rtl/svd_seq_mxn.sv
// Jacobi/CORDIC SVD sequencer for 2^ROW_AW x 2^COL_AW matrices.
// Define SVD_SEQ_EARLY_EXIT_EN to stop once a whole sweep rotates small.
module svd_seq_mxn #(
  parameter int ROW_AW     = 3,
  parameter int COL_AW     = 2,
  parameter int N_SWEEP    = 6,
  parameter int CORDIC_LAT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  input  logic              rot_small,
  output logic [COL_AW-1:0] col_idx,
  output logic [COL_AW-1:0] col_p,
  output logic [COL_AW-1:0] col_q,
  output logic              ce_rot,
  output logic              we_a,
  output logic              we_v,
  output logic              clr_v,
  output logic              busy,
  output logic [3:0]        sweep_cnt,
  output logic              done
);

  if (ROW_AW < 1 || COL_AW < 1 ||
      N_SWEEP < 1 || N_SWEEP > 15 ||
      CORDIC_LAT < 1 || CORDIC_LAT > 255)
  begin : g_bad_cfg
    $error("svd_seq_mxn: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROT,
    S_WAIT,
    S_WB,
    S_UNLOAD
  } state_t;

  localparam logic [COL_AW-1:0] C_LAST = '1;
  localparam logic [COL_AW-1:0] C_ONE  = COL_AW'(1);
  localparam logic [7:0]        C_LAT  = 8'(CORDIC_LAT - 1);
  localparam logic [3:0]        C_NSW  = 4'(N_SWEEP);

  state_t            r_state, w_state;
  logic [COL_AW-1:0] r_col, w_col;
  logic [COL_AW-1:0] r_p, w_p;
  logic [COL_AW-1:0] r_q, w_q;
  logic [3:0]        r_sweep, w_sweep;
  logic [7:0]        r_cnt, w_cnt;
  logic              r_done, w_done;
  logic              w_last_pair;
  logic              w_exit;

  assign w_last_pair = (r_q == C_LAST) &&
                       (r_p == C_LAST - C_ONE);

`ifdef SVD_SEQ_EARLY_EXIT_EN
  logic r_small;

  // Re-armed while loading and at every sweep boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_small <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_small <= 1'b1;
    end else if (r_state == S_WB) begin
      r_small <= w_last_pair ? 1'b1 : (r_small & rot_small);
    end
  end

  assign w_exit = r_small & rot_small;
`else
  assign w_exit = rot_small & 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_sweep <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_col   <= w_col;
      r_p     <= w_p;
      r_q     <= w_q;
      r_sweep <= w_sweep;
      r_cnt   <= w_cnt;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_p     = r_p;
    w_q     = r_q;
    w_sweep = r_sweep;
    w_cnt   = r_cnt;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_LOAD;
          w_col   = '0;
          w_sweep = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_col = r_col + C_ONE;
          if (r_col == C_LAST) begin
            w_state = S_ROT;
            w_col   = '0;
            w_p     = '0;
            w_q     = C_ONE;
          end
        end
      end
      S_ROT: begin
        w_cnt   = C_LAT;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state = S_WB;
        else             w_cnt = r_cnt - 8'd1;
      end
      S_WB: begin
        w_state = S_ROT;
        if (!w_last_pair) begin
          if (r_q != C_LAST) begin
            w_q = r_q + C_ONE;
          end else begin
            w_p = r_p + C_ONE;
            w_q = r_p + C_ONE + C_ONE;
          end
        end else begin
          w_sweep = r_sweep + 4'd1;
          w_p     = '0;
          w_q     = C_ONE;
          if (w_sweep == C_NSW || w_exit) begin
            w_state = S_UNLOAD;
            w_col   = '0;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          w_col = r_col + C_ONE;
          if (r_col == C_LAST) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_UNLOAD);
  assign ce_rot    = (r_state == S_ROT);
  assign we_v      = (r_state == S_WB);
  assign we_a      = ((r_state == S_LOAD) & in_valid) |
                     (r_state == S_WB);
  assign clr_v     = (r_state == S_IDLE) & start;
  assign busy      = (r_state != S_IDLE);
  assign col_idx   = r_col;
  assign col_p     = r_p;
  assign col_q     = r_q;
  assign sweep_cnt = r_sweep;
  assign done      = r_done;

endmodule
